// File: rtl/cam_pkg.sv
// Shared types for the two-camera buffer/handoff controller.
package cam_pkg;

  localparam int PCT_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILM  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } cam_state_t;

endpackage

// File: rtl/cam_channel.sv
// One camera: IDLE/FILM/HOLD/DRAIN state machine plus its saturating fill counter.
// With CAM_PAUSE_EN defined, pause_i freezes the counter without blocking state changes.
module cam_channel
  import cam_pkg::*;
#(
  parameter bit START_FILM = 1'b0,
  parameter int MAX_PCT    = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_film_i,
  input  logic             release_i,
  input  logic             flush_i,
  input  logic             dl_i,
  input  logic             tick_i,
`ifdef CAM_PAUSE_EN
  input  logic             pause_i,
`endif
  output cam_state_t       state_o,
  output logic [PCT_W-1:0] pct_o,
  output logic             ovf_o
);

  localparam logic [PCT_W-1:0] MAX_LVL = PCT_W'(MAX_PCT);

  cam_state_t       state_q, state_d;
  logic [PCT_W-1:0] pct_q, pct_d;
  logic             ovf_q, ovf_d;
  logic             cnt_en;

`ifdef CAM_PAUSE_EN
  assign cnt_en = tick_i & ~pause_i;
`else
  assign cnt_en = tick_i;
`endif

  // NOTE: every next-state value is defaulted to its current value first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    pct_d   = pct_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start_film_i) begin
          state_d = FILM;
          pct_d   = '0;
        end
      end
      FILM: begin
        // Handing off freezes the level that triggered it.
        if (release_i) begin
          state_d = HOLD;
        end else if (cnt_en) begin
          if (pct_q >= MAX_LVL) ovf_d = 1'b1;
          else                  pct_d = pct_q + 1'b1;
        end
      end
      HOLD: begin
        if (dl_i) begin
          state_d = DRAIN;
        end else if (flush_i) begin
          state_d = IDLE;
          pct_d   = '0;
        end
      end
      DRAIN: begin
        if (pct_q == '0)  state_d = IDLE;
        else if (cnt_en)  pct_d   = pct_q - 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= START_FILM ? FILM : IDLE;
      pct_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pct_q   <= pct_d;
      ovf_q   <= ovf_d;
    end
  end

  assign state_o = state_q;
  assign pct_o   = pct_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/cam_handoff_ctrl.sv
// Two-camera handoff controller: arbitrates handoff, flush and standby between two cam_channel instances.
// Optional CAM_PAUSE_EN adds pause1/pause2 inputs that freeze each camera's count.
module cam_handoff_ctrl
  import cam_pkg::*;
#(
  parameter int START_CAM   = 0,
  parameter int STBY_PCT    = 80,
  parameter int HANDOFF_PCT = 90,
  parameter int FLUSH_PCT   = 50,
  parameter int MAX_PCT     = 100
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             dl1,
  input  logic             dl2,
`ifdef CAM_PAUSE_EN
  input  logic             pause1,
  input  logic             pause2,
`endif
  output logic [PCT_W-1:0] pct1,
  output logic [PCT_W-1:0] pct2,
  output logic             film1,
  output logic             film2,
  output logic             standby1,
  output logic             standby2,
  output logic             hold1,
  output logic             hold2,
  output logic             ovf1,
  output logic             ovf2
);

  localparam logic [PCT_W-1:0] STBY_LVL    = PCT_W'(STBY_PCT);
  localparam logic [PCT_W-1:0] HANDOFF_LVL = PCT_W'(HANDOFF_PCT);
  localparam logic [PCT_W-1:0] FLUSH_LVL   = PCT_W'(FLUSH_PCT);

  cam_state_t state1, state2;
  logic       handoff_12, handoff_21;
  logic       flush1, flush2;

  // A camera passes filming only to an IDLE peer, so at most one camera ever films.
  assign handoff_12 = (state1 == FILM) && (pct1 >= HANDOFF_LVL) && (state2 == IDLE);
  assign handoff_21 = (state2 == FILM) && (pct2 >= HANDOFF_LVL) && (state1 == IDLE);

  assign flush1 = (state1 == HOLD) && (state2 == FILM) && (pct2 >= FLUSH_LVL);
  assign flush2 = (state2 == HOLD) && (state1 == FILM) && (pct1 >= FLUSH_LVL);

  cam_channel #(
    .START_FILM (START_CAM == 0),
    .MAX_PCT    (MAX_PCT)
  ) u_cam1 (
    .clk          (clock),
    .rst_n        (reset_n),
    .start_film_i (handoff_21),
    .release_i    (handoff_12),
    .flush_i      (flush1),
    .dl_i         (dl1),
    .tick_i       (tick),
`ifdef CAM_PAUSE_EN
    .pause_i      (pause1),
`endif
    .state_o      (state1),
    .pct_o        (pct1),
    .ovf_o        (ovf1)
  );

  cam_channel #(
    .START_FILM (START_CAM != 0),
    .MAX_PCT    (MAX_PCT)
  ) u_cam2 (
    .clk          (clock),
    .rst_n        (reset_n),
    .start_film_i (handoff_12),
    .release_i    (handoff_21),
    .flush_i      (flush2),
    .dl_i         (dl2),
    .tick_i       (tick),
`ifdef CAM_PAUSE_EN
    .pause_i      (pause2),
`endif
    .state_o      (state2),
    .pct_o        (pct2),
    .ovf_o        (ovf2)
  );

  assign film1    = (state1 == FILM);
  assign film2    = (state2 == FILM);
  assign hold1    = (state1 == HOLD);
  assign hold2    = (state2 == HOLD);
  assign standby1 = (state1 == IDLE) && (state2 == FILM) && (pct2 >= STBY_LVL);
  assign standby2 = (state2 == IDLE) && (state1 == FILM) && (pct1 >= STBY_LVL);

endmodule

// File: tb/tb_cam_handoff_ctrl.sv
// Self-checking bench for cam_handoff_ctrl: table of phases with hand-derived expected outputs,
// plus hand-written async-reset, idle-download and (with CAM_PAUSE_EN) pause sequences.
module tb_cam_handoff_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       tick, dl1, dl2;
`ifdef CAM_PAUSE_EN
  logic       pause1, pause2;
`endif
  logic [6:0] pct1, pct2;
  logic       film1, film2, standby1, standby2, hold1, hold2, ovf1, ovf2;

  // flags: film1 film2 standby1 standby2 hold1 hold2 ovf1 ovf2
  typedef struct packed {
    logic [6:0] pct1;
    logic [6:0] pct2;
    logic [7:0] flags;
  } out_t;

  typedef struct {
    int   cycles;
    bit   tick;
    bit   dl1;
    bit   dl2;
    out_t exp;
  } vec_t;

  vec_t vecs[$];
  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  cam_handoff_ctrl dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .tick     (tick),
    .dl1      (dl1),
    .dl2      (dl2),
`ifdef CAM_PAUSE_EN
    .pause1   (pause1),
    .pause2   (pause2),
`endif
    .pct1     (pct1),
    .pct2     (pct2),
    .film1    (film1),
    .film2    (film2),
    .standby1 (standby1),
    .standby2 (standby2),
    .hold1    (hold1),
    .hold2    (hold2),
    .ovf1     (ovf1),
    .ovf2     (ovf2)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic out_t actual();
    out_t a;
    a = {pct1, pct2, film1, film2, standby1, standby2, hold1, hold2, ovf1, ovf2};
    return a;
  endfunction

  function automatic void add(int c, bit t, bit d1, bit d2,
                              logic [6:0] p1, logic [6:0] p2, logic [7:0] fl);
    vec_t v;
    v.cycles = c;
    v.tick   = t;
    v.dl1    = d1;
    v.dl2    = d2;
    v.exp    = {p1, p2, fl};
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got pct1=%0d pct2=%0d flags=%b, expected pct1=%0d pct2=%0d flags=%b",
               name, act.pct1, act.pct2, act.flags, exp.pct1, exp.pct2, exp.flags);
    end
  endtask

  task automatic step(input bit t, input bit d1, input bit d2);
    tick = t;
    dl1  = d1;
    dl2  = d2;
    @(posedge clock);
    #1;
  endtask

  initial begin
    out_t rst_exp;
    rst_exp = {7'd0, 7'd0, 8'b1000_0000};

    // Reset, standby boundary 79/80, handoff boundary 89/90.
    add(1,  0, 0, 0, 7'd0,   7'd0,  8'b1000_0000);
    add(79, 1, 0, 0, 7'd79,  7'd0,  8'b1000_0000);
    add(1,  1, 0, 0, 7'd80,  7'd0,  8'b1001_0000);
    add(10, 1, 0, 0, 7'd90,  7'd0,  8'b1001_0000);
    add(1,  0, 0, 0, 7'd90,  7'd0,  8'b0100_1000);
    // cam2 films (dl2 ignored in FILM); flush of cam1 at pct2=50.
    add(49, 1, 0, 1, 7'd90,  7'd49, 8'b0100_1000);
    add(1,  1, 0, 0, 7'd90,  7'd50, 8'b0100_1000);
    add(1,  0, 0, 0, 7'd0,   7'd50, 8'b0100_0000);
    add(29, 1, 0, 0, 7'd0,   7'd79, 8'b0100_0000);
    add(1,  1, 0, 0, 7'd0,   7'd80, 8'b0110_0000);
    add(10, 1, 0, 0, 7'd0,   7'd90, 8'b0110_0000);
    add(1,  0, 0, 0, 7'd0,   7'd90, 8'b1000_0100);
    // Download and flush coincide: download wins, cam2 drains.
    add(49, 1, 0, 0, 7'd49,  7'd90, 8'b1000_0100);
    add(1,  1, 0, 0, 7'd50,  7'd90, 8'b1000_0100);
    add(1,  0, 0, 1, 7'd50,  7'd90, 8'b1000_0000);
    // cam1 passes handoff level while cam2 drains: no handoff, saturation and ovf.
    add(39, 1, 1, 0, 7'd89,  7'd51, 8'b1000_0000);
    add(1,  1, 0, 0, 7'd90,  7'd50, 8'b1000_0000);
    add(1,  0, 0, 0, 7'd90,  7'd50, 8'b1000_0000);
    add(10, 1, 0, 0, 7'd100, 7'd40, 8'b1000_0000);
    add(1,  1, 0, 0, 7'd100, 7'd39, 8'b1000_0010);
    add(39, 1, 0, 0, 7'd100, 7'd0,  8'b1000_0010);
    // Drain end with a tick (no underflow), then handoff once cam2 is IDLE.
    add(1,  1, 0, 0, 7'd100, 7'd0,  8'b1001_0010);
    add(1,  0, 0, 0, 7'd100, 7'd0,  8'b0100_1010);
    add(1,  0, 1, 0, 7'd100, 7'd0,  8'b0100_0010);
    add(5,  1, 0, 0, 7'd95,  7'd5,  8'b0100_0010);

    reset_n = 1'b0;
    tick    = 1'b0;
    dl1     = 1'b0;
    dl2     = 1'b0;
`ifdef CAM_PAUSE_EN
    pause1  = 1'b0;
    pause2  = 1'b0;
`endif
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].exp);
      for (int c = 0; c < vecs[i].cycles; c++) step(vecs[i].tick, vecs[i].dl1, vecs[i].dl2);
      check($sformatf("vec%0d", i), actual(), exp_q.pop_front());
    end

    // Async reset mid-DRAIN, away from any clock edge.
    #2;
    reset_n = 1'b0;
    exp_q.push_back(rst_exp);
    #1;
    check("async_reset", actual(), exp_q.pop_front());

    exp_q.push_back(rst_exp);
    for (int c = 0; c < 3; c++) step(1, 1, 1);
    check("held_reset", actual(), exp_q.pop_front());

    reset_n = 1'b1;
    exp_q.push_back(rst_exp);
    step(0, 0, 0);
    check("reset_release", actual(), exp_q.pop_front());

    // dl2 while cam2 is IDLE is ignored.
    exp_q.push_back({7'd3, 7'd0, 8'b1000_0000});
    for (int c = 0; c < 3; c++) step(1, 0, 1);
    check("dl_idle", actual(), exp_q.pop_front());

`ifdef CAM_PAUSE_EN
    pause1 = 1'b1;
    exp_q.push_back({7'd3, 7'd0, 8'b1000_0000});
    for (int c = 0; c < 10; c++) step(1, 0, 0);
    check("pause_film", actual(), exp_q.pop_front());
    pause1 = 1'b0;
    exp_q.push_back({7'd5, 7'd0, 8'b1000_0000});
    for (int c = 0; c < 2; c++) step(1, 0, 0);
    check("unpause_film", actual(), exp_q.pop_front());
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
